sc_bus_arbiter: RTL

//  Shares the single-cycle data bus (MEM / LED-bar / TTY decoder) between two masters:
//  m0 = CPU data port, m1 = loader/debug port. Per-transfer req/ack handshake, registered

---
 rtl/sc_bus_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/sc_bus_arbiter.sv
// Two-master arbiter for the single-cycle data bus (CPU data port m0, loader/debug port m1).
// Optional round-robin tie-breaking is enabled by defining SC_ARB_RR_EN; otherwise m0 has fixed priority.
module sc_bus_arbiter #(
  parameter int ACK_LAT  = 1,
  parameter int LOCK_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [3:0]  m0_be_i,
  input  logic        m0_we_i,
  input  logic        m0_lock_i,
  output logic        m0_gnt_o,
  output logic        m0_ack_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_be_i,
  input  logic        m1_we_i,
  input  logic        m1_lock_i,
  output logic        m1_gnt_o,
  output logic        m1_ack_o,
  output logic [31:0] m1_rdata_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o,
  output logic        we_o,
  input  logic [31:0] rdata_i
);

  localparam logic [3:0] CntInit = 4'(ACK_LAT - 1);
  localparam logic [3:0] LockLim = 4'(LOCK_MAX - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, ACK = 2'd2} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        locked_q, locked_d;
  logic [3:0]  lockCnt_q, lockCnt_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

  logic req0Ok, req1Ok, pick1, lockReq;

  // While locked, only the current owner may compete for the next transfer.
  assign req0Ok  = m0_req_i && !(locked_q && owner_q);
  assign req1Ok  = m1_req_i && !(locked_q && !owner_q);
  assign lockReq = owner_q ? m1_lock_i : m0_lock_i;

`ifdef SC_ARB_RR_EN
  assign pick1 = req1Ok && (!req0Ok || !owner_q);
`else
  assign pick1 = req1Ok && !req0Ok;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      owner_q   <= 1'b1;
      locked_q  <= 1'b0;
      lockCnt_q <= 4'd0;
      cnt_q     <= 4'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      be_q      <= 4'd0;
      we_q      <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      rdata0_q  <= 32'd0;
      rdata1_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      locked_q  <= locked_d;
      lockCnt_q <= lockCnt_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      we_q      <= we_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    locked_d  = locked_q;
    lockCnt_d = lockCnt_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    we_d      = we_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;

    unique case (state_q)
      IDLE: begin
        if (req0Ok || req1Ok) begin
          state_d = XFER;
          owner_d = pick1;
          cnt_d   = CntInit;
          addr_d  = pick1 ? m1_addr_i  : m0_addr_i;
          wdata_d = pick1 ? m1_wdata_i : m0_wdata_i;
          be_d    = pick1 ? m1_be_i    : m0_be_i;
          we_d    = pick1 ? m1_we_i    : m0_we_i;
        end
      end
      XFER: begin
        // The write strobe only lives for the first command cycle.
        we_d = 1'b0;
        if (cnt_q == 4'd0) begin
          state_d = ACK;
          addr_d  = 32'd0;
          wdata_d = 32'd0;
          be_d    = 4'd0;
          if (owner_q) begin
            rdata1_d = rdata_i;
            ack1_d   = 1'b1;
          end else begin
            rdata0_d = rdata_i;
            ack0_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
        if (lockReq && (lockCnt_q < LockLim)) begin
          locked_d  = 1'b1;
          lockCnt_d = lockCnt_q + 4'd1;
        end else begin
          locked_d  = 1'b0;
          lockCnt_d = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m0_gnt_o   = (state_q != IDLE) && !owner_q;
  assign m1_gnt_o   = (state_q != IDLE) && owner_q;
  assign m0_ack_o   = ack0_q;
  assign m1_ack_o   = ack1_q;
  assign m0_rdata_o = rdata0_q;
  assign m1_rdata_o = rdata1_q;
  assign addr_o     = addr_q;
  assign wdata_o    = wdata_q;
  assign be_o       = be_q;
  assign we_o       = we_q;

endmodule
